ro_measure_ctrl: RTL and testbench

RO_MEASURE_CTRL -- requirements
Module: ro_measure_ctrl

---
 rtl/ro_puf_pkg.sv | 32 +++
 rtl/ro_measure_ctrl_if.sv | 32 +++
 rtl/ro_window_timer.sv | 28 ++
 rtl/ro_measure_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ro_measure_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ro_puf_pkg.sv
// Shared definitions for the ring-oscillator PUF measurement controller:
// FSM encoding, default parameter values and small elaboration helpers.
package ro_puf_pkg;

  localparam int unsigned CntWidthDef = 32;
  localparam int unsigned RespBitsDef = 8;
  localparam int unsigned WindowDef   = 1024;
  localparam int unsigned SettleDef   = 4;
  localparam int unsigned ClearCycDef = 2;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StRun     = 3'd2,
    StSettle  = 3'd3,
    StCompare = 3'd4,
    StDone    = 3'd5
  } ro_state_e;

  // Bits needed to hold the values 0 .. n-1 (never less than one bit).
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ro_measure_ctrl_if.sv
// Bundle between the measurement controller and its surroundings: request
// handshake, RO counter readback, oscillator control and the response.
interface ro_measure_ctrl_if #(
  parameter int unsigned CNT_WIDTH = ro_puf_pkg::CntWidthDef,
  parameter int unsigned RESP_BITS = ro_puf_pkg::RespBitsDef
);

  logic                 start;
  logic [7:0]           challenge;
  logic [CNT_WIDTH-1:0] count_a;
  logic [CNT_WIDTH-1:0] count_b;
  logic [7:0]           pair_sel;
  logic                 ro_enable;
  logic                 ctr_clear;
  logic                 busy;
  logic                 done;
  logic [RESP_BITS-1:0] response;
  logic [7:0]           tie_cnt;

  // Requester / RO counter side.
  modport master (
    output start, challenge, count_a, count_b,
    input  pair_sel, ro_enable, ctr_clear, busy, done, response, tie_cnt
  );

  // Controller side.
  modport slave (
    input  start, challenge, count_a, count_b,
    output pair_sel, ro_enable, ctr_clear, busy, done, response, tie_cnt
  );

endinterface

// File: rtl/ro_window_timer.sv
// Down-counter shared by the CLEAR, RUN and SETTLE phases. Loading N-1 makes
// the expire flag rise on the N-th cycle after the load.
module ro_window_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator PUF measurement controller: for each response bit it clears
// the RO counters, runs the selected oscillator pair for a fixed window, lets
// the divided RO clocks drain, then compares the two counts.
module ro_measure_ctrl
  import ro_puf_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CntWidthDef,
  parameter int unsigned RESP_BITS = RespBitsDef,
  parameter int unsigned WINDOW    = WindowDef,
  parameter int unsigned SETTLE    = SettleDef,
  parameter int unsigned CLEAR_CYC = ClearCycDef
) (
  input logic              Clock,
  input logic              Reset,
  ro_measure_ctrl_if.slave io_bus
);

  // WINDOW, SETTLE and CLEAR_CYC are expected to be at least 1.
  localparam int unsigned TimerW = cnt_bits(max3(WINDOW, SETTLE, CLEAR_CYC));
  localparam int unsigned IdxW   = cnt_bits(RESP_BITS);

  ro_state_e r_state;
  ro_state_e w_state_next;

  logic [7:0]           r_challenge;
  logic [IdxW-1:0]      r_index;
  logic [RESP_BITS-1:0] r_response;
  logic [7:0]           r_tie_cnt;

  logic                 w_load;
  logic [TimerW-1:0]    w_load_val;
  logic                 w_expired;

  logic [CNT_WIDTH-1:0] w_count_a;
  logic [CNT_WIDTH-1:0] w_count_b;
  logic                 w_accept;
  logic                 w_bit;
  logic                 w_tie;
  logic                 w_last;

  logic                 w_ro_enable;
  logic                 w_ctr_clear;
  logic                 w_busy;
  logic                 w_done;

  assign w_count_a = io_bus.count_a;
  assign w_count_b = io_bus.count_b;
  assign w_accept  = (r_state == StIdle) && io_bus.start;
  assign w_bit     = (w_count_a > w_count_b);
  assign w_tie     = (w_count_a == w_count_b);
  assign w_last    = (r_index == IdxW'(RESP_BITS - 1));

  ro_window_timer #(
    .WIDTH (TimerW)
  ) u_timer (
    .Clock      (Clock),
    .Reset      (Reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_expired  (w_expired)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, timer loads on phase entry, and state-decoded outputs.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_ro_enable  = 1'b0;
    w_ctr_clear  = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_ctr_clear = 1'b1;
        w_busy      = 1'b0;
        if (io_bus.start) begin
          w_state_next = StClear;
          w_load       = 1'b1;
          w_load_val   = TimerW'(CLEAR_CYC - 1);
        end
      end
      StClear: begin
        w_ctr_clear = 1'b1;
        if (w_expired) begin
          w_state_next = StRun;
          w_load       = 1'b1;
          w_load_val   = TimerW'(WINDOW - 1);
        end
      end
      StRun: begin
        w_ro_enable = 1'b1;
        if (w_expired) begin
          w_state_next = StSettle;
          w_load       = 1'b1;
          w_load_val   = TimerW'(SETTLE - 1);
        end
      end
      StSettle: begin
        if (w_expired) begin
          w_state_next = StCompare;
        end
      end
      StCompare: begin
        if (w_last) begin
          w_state_next = StDone;
        end else begin
          w_state_next = StClear;
          w_load       = 1'b1;
          w_load_val   = TimerW'(CLEAR_CYC - 1);
        end
      end
      StDone: begin
        w_ctr_clear  = 1'b1;
        w_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Challenge capture, bit index, response shift and tie counting.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_challenge <= '0;
      r_index     <= '0;
      r_response  <= '0;
      r_tie_cnt   <= '0;
    end else if (w_accept) begin
      r_challenge <= io_bus.challenge;
      r_index     <= '0;
      r_response  <= '0;
      r_tie_cnt   <= '0;
    end else if (r_state == StCompare) begin
      // First measured bit ends up in the MSB.
      r_response <= RESP_BITS'({r_response, w_bit});
      if (w_tie && (r_tie_cnt != 8'hFF)) begin
        r_tie_cnt <= r_tie_cnt + 8'd1;
      end
      if (!w_last) begin
        r_index <= r_index + IdxW'(1);
      end
    end
  end

  assign io_bus.pair_sel  = r_challenge + 8'(r_index);
  assign io_bus.ro_enable = w_ro_enable;
  assign io_bus.ctr_clear = w_ctr_clear;
  assign io_bus.busy      = w_busy;
  assign io_bus.done      = w_done;
  assign io_bus.response  = r_response;
  assign io_bus.tie_cnt   = r_tie_cnt;

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Bench for ro_measure_ctrl with a short window: a timeline model predicts
// every output each cycle, directed responses pin the model with literals.
module tb_ro_measure_ctrl;

  localparam int unsigned CntW    = 32;
  localparam int unsigned RespB   = 4;
  localparam int unsigned Win     = 16;
  localparam int unsigned Settle  = 4;
  localparam int unsigned ClrC    = 2;
  localparam int          BitCyc  = ClrC + Win + Settle + 1;
  localparam int          Total   = RespB * BitCyc;
  localparam int          NoReset = 1000;

  logic Clock;
  logic Reset;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: phase -1 = idle, 0..Total-1 = measuring, Total = done cycle.
  int m_phase = -1;
  int m_base  = 0;
  int m_resp  = 0;
  int m_tie   = 0;
  int m_pair  = 0;

  ro_measure_ctrl_if #(.CNT_WIDTH(CntW), .RESP_BITS(RespB)) bus ();

  ro_measure_ctrl #(
    .CNT_WIDTH (CntW),
    .RESP_BITS (RespB),
    .WINDOW    (Win),
    .SETTLE    (Settle),
    .CLEAR_CYC (ClrC)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .io_bus (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Compare process: predict outputs from the timeline, check, then advance.
  always @(negedge Clock) begin : cmp
    int b, o;
    logic e_en, e_clr, e_busy, e_done;
    int e_pair;
    b = 0;
    o = 0;
    if (Reset) begin
      m_phase = -1;
      m_resp  = 0;
      m_tie   = 0;
      m_pair  = 0;
    end
    if (m_phase < 0) begin
      e_en = 0; e_clr = 1; e_busy = 0; e_done = 0; e_pair = m_pair;
    end else if (m_phase == Total) begin
      e_en = 0; e_clr = 1; e_busy = 1; e_done = 1;
      e_pair = (m_base + RespB - 1) % 256;
    end else begin
      b = m_phase / BitCyc;
      o = m_phase % BitCyc;
      e_en   = (o >= ClrC) && (o < ClrC + Win);
      e_clr  = (o < ClrC);
      e_busy = 1;
      e_done = 0;
      e_pair = (m_base + b) % 256;
    end
    check("ro_enable", 32'(bus.ro_enable), 32'(e_en));
    check("ctr_clear", 32'(bus.ctr_clear), 32'(e_clr));
    check("busy", 32'(bus.busy), 32'(e_busy));
    check("done", 32'(bus.done), 32'(e_done));
    check("pair_sel", 32'(bus.pair_sel), 32'(e_pair));
    check("response", 32'(bus.response), 32'(m_resp));
    check("tie_cnt", 32'(bus.tie_cnt), 32'(m_tie));
    if (!Reset) begin
      if (m_phase < 0) begin
        if (bus.start) begin
          m_phase = 0;
          m_base  = int'(bus.challenge);
          m_pair  = int'(bus.challenge);
          m_resp  = 0;
          m_tie   = 0;
        end
      end else if (m_phase == Total) begin
        m_phase = -1;
        m_pair  = (m_base + RespB - 1) % 256;
      end else begin
        if (o == BitCyc - 1) begin
          m_resp = ((m_resp << 1) | ((bus.count_a > bus.count_b) ? 1 : 0)) % (1 << RespB);
          if ((bus.count_a == bus.count_b) && (m_tie < 255)) m_tie++;
        end
        m_phase++;
      end
    end
  end

  // One response request; counts per bit come from ca/cb (index 0 = first bit).
  task automatic run_resp(input string tag, input logic [7:0] ch,
                          input logic [0:3][31:0] ca, input logic [0:3][31:0] cb,
                          input logic [0:3][7:0] pairs, input int busy_at,
                          input int reset_at, input logic [3:0] exp_resp,
                          input logic [7:0] exp_tie);
    int lat, n_done, bi;
    int en_cnt[4];
    lat    = -1;
    n_done = 0;
    for (int i = 0; i < 4; i++) en_cnt[i] = 0;
    bus.start     = 1'b1;
    bus.challenge = ch;
    bus.count_a   = ca[0];
    bus.count_b   = cb[0];
    @(posedge Clock);
    #2;
    bus.start     = 1'b0;
    bus.challenge = ~ch;
    for (int c = 0; c < 100; c++) begin
      bi = c / BitCyc;
      if (bi > 3) bi = 3;
      bus.count_a = ca[bi];
      bus.count_b = cb[bi];
      if (c == busy_at) bus.start = 1'b1;
      if (c == busy_at + 1) bus.start = 1'b0;
      if (c == reset_at) Reset = 1'b1;
      if (c == reset_at + 3) Reset = 1'b0;
      @(negedge Clock);
      if (c == reset_at) begin
        check({tag, "_rst_ro_enable"}, 32'(bus.ro_enable), 32'd0);
        check({tag, "_rst_busy"}, 32'(bus.busy), 32'd0);
      end
      if ((c % BitCyc == 0) && (c < Total) && (c < reset_at))
        check($sformatf("%s_pair%0d", tag, bi), 32'(bus.pair_sel), 32'(pairs[bi]));
      if (bus.ro_enable && c < Total) en_cnt[bi]++;
      if (bus.done) begin
        n_done++;
        if (lat < 0) lat = c;
      end
      @(posedge Clock);
      #2;
    end
    if (reset_at < NoReset) begin
      check({tag, "_no_done"}, 32'(n_done), 32'd0);
    end else begin
      check({tag, "_latency"}, 32'(lat), 32'd92);
      check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
      check({tag, "_response"}, 32'(bus.response), 32'(exp_resp));
      check({tag, "_tie_cnt"}, 32'(bus.tie_cnt), 32'(exp_tie));
      for (int i = 0; i < 4; i++)
        check($sformatf("%s_ro_en_cycles%0d", tag, i), 32'(en_cnt[i]), 32'd16);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    Reset         = 1'b1;
    bus.start     = 1'b0;
    bus.challenge = 8'h00;
    bus.count_a   = '0;
    bus.count_b   = '0;
    repeat (3) @(posedge Clock);
    #2;
    Reset = 1'b0;
    @(negedge Clock);
    check("reset_ctr_clear", 32'(bus.ctr_clear), 32'd1);
    check("reset_ro_enable", 32'(bus.ro_enable), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_response", 32'(bus.response), 32'd0);
    @(posedge Clock);
    #2;

    // All bits a > b.
    run_resp("all_gt", 8'h10, {32'd100, 32'd100, 32'd100, 32'd100},
             {32'd90, 32'd90, 32'd90, 32'd90}, {8'h10, 8'h11, 8'h12, 8'h13},
             NoReset, NoReset, 4'b1111, 8'd0);

    // Greater, smaller, equal, greater.
    run_resp("mixed", 8'h40, {32'd100, 32'd50, 32'd70, 32'd9},
             {32'd90, 32'd60, 32'd70, 32'd8}, {8'h40, 8'h41, 8'h42, 8'h43},
             NoReset, NoReset, 4'b1001, 8'd1);

    // Pair index wrap plus full-width unsigned compares.
    run_resp("wrap", 8'hFE, {32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0},
             {32'd1, 32'h8000_0000, 32'hFFFF_FFFE, 32'd0}, {8'hFE, 8'hFF, 8'h00, 8'h01},
             NoReset, NoReset, 4'b1010, 8'd1);

    // Reset during RUN of bit 2, then a clean response.
    run_resp("abort", 8'h20, {32'd5, 32'd5, 32'd5, 32'd5},
             {32'd1, 32'd1, 32'd1, 32'd1}, {8'h20, 8'h21, 8'h22, 8'h23},
             NoReset, 2 * BitCyc + 5, 4'b0000, 8'd0);
    run_resp("after_abort", 8'h30, {32'd5, 32'd5, 32'd7, 32'd0},
             {32'd3, 32'd9, 32'd7, 32'd1}, {8'h30, 8'h31, 8'h32, 8'h33},
             NoReset, NoReset, 4'b1000, 8'd1);

    // start pulsed while busy is ignored.
    run_resp("busy_start", 8'h80, {32'd1, 32'd9, 32'd9, 32'd1},
             {32'd2, 32'd3, 32'd4, 32'd5}, {8'h80, 8'h81, 8'h82, 8'h83},
             40, NoReset, 4'b0110, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
